rom_wr: RTL and testbench

ROM_WR -- requirements
Module: rom_wr

---
 rtl/rom_wr_pkg.sv | 27 ++
 rtl/rom_wr.sv | 66 ++++++
 tb/tb_rom_wr.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_wr_pkg.sv
// Shared definitions for the word-to-byte serializer: FSM encodings, size codes,
// enable levels and the byte-total helper.
package rom_wr_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_DATA = 2'b01,
    S_DONE = 2'b10,
    S_BAD  = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    SZ_1B = 2'b00,
    SZ_2B = 2'b01,
    SZ_4B = 2'b10,
    SZ_8B = 2'b11
  } size_t;

  // Number of bytes to emit for a size code (1, 2, 4 or 8).
  function automatic logic [3:0] byte_total(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/rom_wr.sv
// Serializes one 64-bit word into 1..8 bytes, little-endian, onto a fifo write
// port, throttled by a registered copy of the fifo's almost_full flag.
module rom_wr
  import rom_wr_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        size,
  output logic              ready,
  output logic              done,
  input  logic              almost_full,
  output logic              wr_en,
  output logic [7:0]        dout
);

  state_t            state;
  logic              can_write;
  logic [2:0]        count;
  logic [3:0]        total;
  logic [DATA_W-1:0] shift;
  logic              last_byte;

  assign ready     = (state == S_IDLE);
  assign done      = (state == S_DONE);
  assign wr_en     = (state == S_DATA) & can_write;
  assign dout      = shift[7:0];
  assign last_byte = ({1'b0, count} == (total - 4'd1));

  // NOTE: every register below uses <= so all of them update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      can_write <= DISABLE;
      count     <= '0;
      total     <= '0;
      shift     <= '0;
    end else begin
      // One cycle of lag on almost_full; the fifo threshold leaves room for it.
      can_write <= ~almost_full;
      case (state)
        S_IDLE: begin
          if (valid) begin
            shift <= data;
            total <= byte_total(size);
            count <= '0;
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (wr_en) begin
            shift <= {8'h00, shift[DATA_W-1:8]};
            count <= count + 3'd1;
            if (last_byte) state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_wr.sv
// Bench for rom_wr: a byte-queue model predicts ready/wr_en/dout/done every
// cycle, while directed scenarios pin exact byte streams and timing.
module tb_rom_wr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [63:0] data = '0;
  logic [1:0]  size = '0;
  logic        almost_full = 1'b0;
  logic        ready, done, wr_en;
  logic [7:0]  dout;

  rom_wr #(.DATA_W(64)) dut (
    .clk(clk), .rst(rst), .valid(valid), .data(data), .size(size),
    .ready(ready), .done(done), .almost_full(almost_full),
    .wr_en(wr_en), .dout(dout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: bytes still owed for the current word, pending done pulse, throttle.
  logic [7:0] exp_q[$];
  bit         done_due = 1'b0;
  bit         cw       = 1'b0;
  bit         live     = 1'b0;

  // Observation logs used by the directed scenarios.
  logic [7:0] wr_log[$];
  int         wr_cyc[$];
  int         acc_cyc[$];
  int         done_cnt = 0;
  int         cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    bit e_ready, e_wr, nd;
    cyc++;
    e_ready = live && (exp_q.size() == 0) && !done_due;
    e_wr    = live && (exp_q.size() > 0) && cw;
    if (live) begin
      check("ready", ready, e_ready);
      check("wr_en", wr_en, e_wr);
      check("done", done, done_due);
      if (e_wr && wr_en === 1'b1) check("dout", dout, exp_q[0]);
    end
    if (wr_en === 1'b1) begin
      wr_log.push_back(dout);
      wr_cyc.push_back(cyc);
    end
    if (done === 1'b1) done_cnt++;
    if (ready === 1'b1 && valid && !rst) acc_cyc.push_back(cyc);
    // Advance the model across the coming rising edge.
    if (rst) begin
      exp_q.delete();
      done_due = 1'b0;
      cw       = 1'b0;
      live     = 1'b1;
    end else if (live) begin
      nd = 1'b0;
      if (e_wr) begin
        void'(exp_q.pop_front());
        nd = (exp_q.size() == 0);
      end
      if (e_ready && valid)
        for (int i = 0; i < (1 << size); i++) exp_q.push_back(data[8*i +: 8]);
      done_due = nd;
      cw       = !almost_full;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    wr_log.delete();
    wr_cyc.delete();
    acc_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic send(input logic [1:0] s, input logic [63:0] d, input bit hold);
    int c0 = acc_cyc.size();
    valid = 1'b1;
    size  = s;
    data  = d;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (acc_cyc.size() != c0) break;
    end
    check("accept_seen", acc_cyc.size() != c0, 1);
    if (!hold) valid = 1'b0;
  endtask

  task automatic wait_log(input int n);
    for (int i = 0; i < 100; i++) begin
      if (wr_log.size() >= n) break;
      tick();
    end
    check("wait_log", wr_log.size() >= n, 1);
  endtask

  initial begin
    int c;
    int n0;
    int mode;
    mode = 0;

    // Reset state
    rst = 1'b1;
    tick(3);
    @(negedge clk);
    #1;
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_dout", dout, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(2);

    // Full 8-byte word, then a held-valid follow-up to measure accept spacing
    clear_logs();
    send(2'd3, 64'h0807060504030201, 1'b1);
    send(2'd0, 64'hAAAA_AAAA_AAAA_AA55, 1'b0);
    tick(5);
    check("w8_count", wr_log.size(), 9);
    for (int i = 0; i < 8 && i < wr_log.size(); i++) check("w8_byte", wr_log[i], i + 1);
    if (wr_log.size() == 9) check("w8_next", wr_log[8], 8'h55);
    if (wr_cyc.size() >= 8) check("w8_back2back", wr_cyc[7] - wr_cyc[0], 7);
    if (wr_cyc.size() >= 1 && acc_cyc.size() >= 1)
      check("w8_latency", wr_cyc[0] - acc_cyc[0], 1);
    if (acc_cyc.size() == 2) check("w8_throughput", acc_cyc[1] - acc_cyc[0], 10);
    check("w8_done", done_cnt, 2);

    // Single byte word; upper bytes must never leave
    clear_logs();
    send(2'd0, 64'hFFFF_FFFF_FFFF_FFAB, 1'b0);
    tick(5);
    check("w1_count", wr_log.size(), 1);
    if (wr_log.size() >= 1) check("w1_byte", wr_log[0], 8'hAB);
    check("w1_done", done_cnt, 1);

    // almost_full high from before accept for 5 cycles
    clear_logs();
    almost_full = 1'b1;
    send(2'd2, 64'hDEAD_BEEF_4433_2211, 1'b0);
    tick(5);
    check("af_hold_quiet", wr_log.size(), 0);
    c = cyc;
    almost_full = 1'b0;
    tick(8);
    if (wr_cyc.size() >= 1) check("af_resume_cycle", wr_cyc[0], c + 2);
    check("af_count", wr_log.size(), 4);
    for (int i = 0; i < 4 && i < wr_log.size(); i++) check("af_byte", wr_log[i], 8'h11 * (i + 1));

    // almost_full rises mid-word
    clear_logs();
    send(2'd3, 64'h1817161514131211, 1'b0);
    wait_log(3);
    almost_full = 1'b1;
    n0 = wr_log.size();
    tick(4);
    check("mid_af_lag", (wr_log.size() - n0) <= 1, 1);
    almost_full = 1'b0;
    tick(12);
    check("mid_af_count", wr_log.size(), 8);
    for (int i = 0; i < 8 && i < wr_log.size(); i++) check("mid_af_byte", wr_log[i], 8'h11 + i);
    check("mid_af_done", done_cnt, 1);

    // Reset after 3 of 8 bytes
    clear_logs();
    send(2'd3, 64'h0807060504030201, 1'b0);
    wait_log(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(6);
    check("abort_count", wr_log.size(), 3);
    check("abort_done", done_cnt, 0);
    check("abort_ready", ready, 1);
    send(2'd1, 64'h7777_7777_7777_BBAA, 1'b0);
    tick(6);
    if (wr_log.size() == 5) begin
      check("restart_b0", wr_log[3], 8'hAA);
      check("restart_b1", wr_log[4], 8'hBB);
    end
    check("restart_count", wr_log.size(), 5);
    check("restart_done", done_cnt, 1);

    // Back-to-back 2-byte words with valid held high
    clear_logs();
    send(2'd1, 64'hEEEE_EEEE_EEEE_0201, 1'b1);
    send(2'd1, 64'hEEEE_EEEE_EEEE_0403, 1'b1);
    send(2'd1, 64'hEEEE_EEEE_EEEE_0605, 1'b1);
    send(2'd1, 64'hEEEE_EEEE_EEEE_0807, 1'b0);
    tick(6);
    check("b2b_accepts", acc_cyc.size(), 4);
    for (int i = 1; i < acc_cyc.size(); i++) check("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], 4);
    check("b2b_count", wr_log.size(), 8);
    for (int i = 0; i < 8 && i < wr_log.size(); i++) check("b2b_byte", wr_log[i], i + 1);
    check("b2b_done", done_cnt, 4);

    // Randomized traffic, throttling and occasional reset against the model
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) mode = $urandom_range(0, 2);
      valid = ($urandom_range(0, 3) != 0);
      size  = 2'($urandom_range(0, 3));
      data  = {$urandom, $urandom};
      case (mode)
        0:       almost_full = ($urandom_range(0, 9) == 0);
        1:       almost_full = 1'($urandom_range(0, 1));
        default: almost_full = ~almost_full;
      endcase
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    valid = 1'b0;
    almost_full = 1'b0;
    tick(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
